// File: rtl/branch_resolve_ex_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_ex_if
// Purpose : groups the EX-stage branch-resolution request signals and the
//           registered result signals into one bundle.
// Signals : i_valid/i_stall/i_flush    - pipeline control for the EX slot
//           i_br/i_jal/i_jalr          - decode flags (at most one high)
//           i_funct3                   - branch condition select
//           i_pc/i_rs1_data/i_rs2_data/i_imm - operands (32 bits each)
//           o_valid/o_redirect/o_target/o_link/o_misalign - registered result
//           o_br_count/o_taken_count   - resolved / taken counters
// Modports: master drives the request side, slave is the resolver.
// ----------------------------------------------------------------------------
interface branch_resolve_ex_if;
  logic        i_valid;
  logic        i_stall;
  logic        i_flush;
  logic        i_br;
  logic        i_jal;
  logic        i_jalr;
  logic [2:0]  i_funct3;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        o_redirect;
  logic [31:0] o_target;
  logic [31:0] o_link;
  logic        o_misalign;
  logic [31:0] o_br_count;
  logic [31:0] o_taken_count;

  modport master (
    output i_valid, i_stall, i_flush, i_br, i_jal, i_jalr, i_funct3,
           i_pc, i_rs1_data, i_rs2_data, i_imm,
    input  o_valid, o_redirect, o_target, o_link, o_misalign,
           o_br_count, o_taken_count
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_br, i_jal, i_jalr, i_funct3,
           i_pc, i_rs1_data, i_rs2_data, i_imm,
    output o_valid, o_redirect, o_target, o_link, o_misalign,
           o_br_count, o_taken_count
  );
endinterface

// File: rtl/branch_resolve_ex.sv
// ----------------------------------------------------------------------------
// branch_resolve_ex
// Purpose : resolves conditional branches, JAL and JALR in the EX stage.
//           Computes the condition, the redirect target and the link value,
//           registers them one cycle later, emits a one-cycle fetch-redirect
//           pulse, and keeps saturating resolved/taken counters.
//           After a redirect the next non-stalled slot is a wrong-path slot
//           (SHADOW) and is discarded.
// Ports   : i_clk   - clock, rising edge
//           i_reset - synchronous active-high reset
//           bus     - branch_resolve_ex_if.slave (requests in, results out)
// ----------------------------------------------------------------------------
module branch_resolve_ex (
  input  logic                   i_clk,
  input  logic                   i_reset,
  branch_resolve_ex_if.slave     bus
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        eq_s;
  logic        ltu_s;
  logic        lt_s;
  logic        cond_s;
  logic        taken_s;
  logic        misalign_s;
  logic        redirect_s;
  logic        capture_s;
  logic        count_br_s;
  logic        count_taken_s;
  logic [31:0] target_s;
  logic [31:0] link_s;

  logic        valid_r;
  logic        redirect_r;
  logic        misalign_r;
  logic [31:0] target_r;
  logic [31:0] link_r;
  logic [31:0] br_count_r;
  logic [31:0] taken_count_r;

  // Saturating increment for the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

  // Operand comparison; signed less-than reuses the unsigned compare
  // when the signs agree.
  always_comb begin
    eq_s  = (bus.i_rs1_data == bus.i_rs2_data);
    ltu_s = (bus.i_rs1_data <  bus.i_rs2_data);
    if (bus.i_rs1_data[31] != bus.i_rs2_data[31]) begin
      lt_s = bus.i_rs1_data[31];
    end else begin
      lt_s = ltu_s;
    end
  end

  // Branch condition selected by funct3; reserved encodings never take.
  always_comb begin
    cond_s = 1'b0;
    case (bus.i_funct3)
      3'b000:  cond_s = eq_s;
      3'b001:  cond_s = ~eq_s;
      3'b100:  cond_s = lt_s;
      3'b101:  cond_s = ~lt_s;
      3'b110:  cond_s = ltu_s;
      3'b111:  cond_s = ~ltu_s;
      default: cond_s = 1'b0;
    endcase
  end

  // Target/link arithmetic (mod 2^32) and capture qualification.
  always_comb begin
    if (bus.i_jalr) begin
      // JALR clears bit 0 of the sum; bit 1 is still checked for alignment.
      target_s = (bus.i_rs1_data + bus.i_imm) & 32'hFFFF_FFFE;
    end else begin
      target_s = bus.i_pc + bus.i_imm;
    end
    link_s        = bus.i_pc + 32'd4;
    taken_s       = (bus.i_br & cond_s) | bus.i_jal | bus.i_jalr;
    misalign_s    = taken_s & target_s[1];
    // A misaligned target raises an exception instead of redirecting fetch.
    redirect_s    = taken_s & ~misalign_s;
    capture_s     = bus.i_valid & ~bus.i_stall & ~bus.i_flush & (state == RUN);
    count_br_s    = capture_s & (bus.i_br | bus.i_jal | bus.i_jalr);
    count_taken_s = capture_s & bus.i_br & cond_s;
  end

  // Wrong-path shadow state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a redirecting capture opens one shadow slot which
  // closes on the first non-stalled cycle; flush always returns to RUN.
  always_comb begin
    state_next = state;
    if (bus.i_flush) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (capture_s && redirect_s) begin
            state_next = SHADOW;
          end else begin
            state_next = RUN;
          end
        end
        SHADOW: begin
          if (bus.i_stall) begin
            state_next = SHADOW;
          end else begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Result registers; the redirect pulse never survives more than one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_r    <= 1'b0;
      redirect_r <= 1'b0;
      misalign_r <= 1'b0;
      target_r   <= 32'h0000_0000;
      link_r     <= 32'h0000_0000;
    end else if (bus.i_flush) begin
      valid_r    <= 1'b0;
      redirect_r <= 1'b0;
      misalign_r <= 1'b0;
    end else if (capture_s) begin
      valid_r    <= 1'b1;
      redirect_r <= redirect_s;
      misalign_r <= misalign_s;
      target_r   <= target_s;
      link_r     <= link_s;
    end else if ((state == RUN) && bus.i_stall) begin
      // Stalled in RUN: result stays visible, only the pulse drops.
      redirect_r <= 1'b0;
    end else begin
      valid_r    <= 1'b0;
      redirect_r <= 1'b0;
      misalign_r <= 1'b0;
    end
  end

  // Saturating resolved / taken counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      br_count_r    <= 32'h0000_0000;
      taken_count_r <= 32'h0000_0000;
    end else begin
      if (count_br_s) begin
        br_count_r <= sat_inc(br_count_r);
      end else begin
        br_count_r <= br_count_r;
      end
      if (count_taken_s) begin
        taken_count_r <= sat_inc(taken_count_r);
      end else begin
        taken_count_r <= taken_count_r;
      end
    end
  end

  assign bus.o_valid       = valid_r;
  assign bus.o_redirect    = redirect_r;
  assign bus.o_misalign    = misalign_r;
  assign bus.o_target      = target_r;
  assign bus.o_link        = link_r;
  assign bus.o_br_count    = br_count_r;
  assign bus.o_taken_count = taken_count_r;

endmodule

// File: tb/tb_branch_resolve_ex.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_ex
// Purpose : self-checking bench for branch_resolve_ex; a table of directed
//           single-instruction vectors plus hand-written multi-cycle
//           sequences for shadow, stall, flush, reset and saturation.
// ----------------------------------------------------------------------------
module tb_branch_resolve_ex;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  logic [31:0] exp_br;
  logic [31:0] exp_tk;

  branch_resolve_ex_if bus ();

  branch_resolve_ex dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        jal;
    logic        jalr;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] target;
    logic [31:0] link;
    logic        redir;
    logic        mis;
    logic [31:0] br_inc;
    logic [31:0] tk_inc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic f,
                       input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm);
    bus.i_valid    = v;
    bus.i_stall    = s;
    bus.i_flush    = f;
    bus.i_br       = br;
    bus.i_jal      = jal;
    bus.i_jalr     = jalr;
    bus.i_funct3   = f3;
    bus.i_pc       = pc;
    bus.i_rs1_data = rs1;
    bus.i_rs2_data = rs2;
    bus.i_imm      = imm;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_brcnt"}, bus.o_br_count, exp_br);
    chk({name, "_tkcnt"}, bus.o_taken_count, exp_tk);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    exp_br  = 32'h0;
    exp_tk  = 32'h0;
    idle();

    //           br    jal   jalr  f3      pc            rs1           rs2           imm           target        link          rd    mis   bri    tki
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b100, 32'h00000100, 32'hFFFFFFFF, 32'h00000001, 32'h00000020, 32'h00000120, 32'h00000104, 1'b1, 1'b0, 32'd1, 32'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'b110, 32'h00000100, 32'hFFFFFFFF, 32'h00000001, 32'h00000020, 32'h00000120, 32'h00000104, 1'b0, 1'b0, 32'd1, 32'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'b000, 32'h00000100, 32'h00000005, 32'h00000005, 32'h00000002, 32'h00000102, 32'h00000104, 1'b0, 1'b1, 32'd1, 32'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'b001, 32'h00000200, 32'h00000005, 32'h00000005, 32'hFFFFFFF8, 32'h000001F8, 32'h00000204, 1'b0, 1'b0, 32'd1, 32'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'b101, 32'h00000300, 32'h00000001, 32'hFFFFFFFF, 32'h00000040, 32'h00000340, 32'h00000304, 1'b1, 1'b0, 32'd1, 32'd1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'b111, 32'h00000300, 32'h00000001, 32'hFFFFFFFF, 32'h00000040, 32'h00000340, 32'h00000304, 1'b0, 1'b0, 32'd1, 32'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h00000400, 32'h00000007, 32'h00000007, 32'h00000004, 32'h00000404, 32'h00000404, 1'b0, 1'b0, 32'd1, 32'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000010, 32'h0000000C, 32'h00000000, 1'b1, 1'b0, 32'd1, 32'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h00000500, 32'h00001003, 32'h00000000, 32'h00000002, 32'h00001004, 32'h00000504, 1'b1, 1'b0, 32'd1, 32'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 3'b000, 32'h00000500, 32'h00001000, 32'h00000000, 32'h00000003, 32'h00001002, 32'h00000504, 1'b0, 1'b1, 32'd1, 32'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'b000, 32'h00000010, 32'h00000000, 32'h00000000, 32'h00000006, 32'h00000016, 32'h00000014, 1'b0, 1'b1, 32'd1, 32'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 3'b100, 32'h00000600, 32'h80000000, 32'hFFFFFFFF, 32'h00000100, 32'h00000700, 32'h00000604, 1'b1, 1'b0, 32'd1, 32'd1};

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_valid",    {31'd0, bus.o_valid},    32'd0);
    chk("rst_redirect", {31'd0, bus.o_redirect}, 32'd0);
    chk("rst_misalign", {31'd0, bus.o_misalign}, 32'd0);
    chk("rst_target",   bus.o_target,            32'h0);
    chk("rst_link",     bus.o_link,              32'h0);
    chk_cnt("rst");
    reset = 1'b0;
    step();

    // Table-driven single instructions, each followed by a bubble
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0, vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].f3,
            vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      step();
      exp_br = exp_br + vecs[i].br_inc;
      exp_tk = exp_tk + vecs[i].tk_inc;
      chk($sformatf("v%0d_valid", i),    {31'd0, bus.o_valid},    32'd1);
      chk($sformatf("v%0d_redirect", i), {31'd0, bus.o_redirect}, {31'd0, vecs[i].redir});
      chk($sformatf("v%0d_misalign", i), {31'd0, bus.o_misalign}, {31'd0, vecs[i].mis});
      chk($sformatf("v%0d_target", i),   bus.o_target,            vecs[i].target);
      chk($sformatf("v%0d_link", i),     bus.o_link,              vecs[i].link);
      chk_cnt($sformatf("v%0d", i));
      idle();
      step();
      chk($sformatf("v%0d_bub_valid", i),    {31'd0, bus.o_valid},    32'd0);
      chk($sformatf("v%0d_bub_redirect", i), {31'd0, bus.o_redirect}, 32'd0);
    end

    // JALR redirect, then the shadow slot drops a valid instruction
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h700, 32'h1003, 32'h0, 32'h2);
    step();
    exp_br = exp_br + 32'd1;
    chk("jalr_target",   bus.o_target,            32'h1004);
    chk("jalr_redirect", {31'd0, bus.o_redirect}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h800, 32'h1, 32'h1, 32'h8);
    step();
    chk("shadow_redirect", {31'd0, bus.o_redirect}, 32'd0);
    chk("shadow_valid",    {31'd0, bus.o_valid},    32'd0);
    chk_cnt("shadow");
    step();
    exp_br = exp_br + 32'd1;
    exp_tk = exp_tk + 32'd1;
    chk("post_shadow_valid",  {31'd0, bus.o_valid}, 32'd1);
    chk("post_shadow_target", bus.o_target,         32'h808);
    chk_cnt("post_shadow");
    idle();
    step();

    // Taken BNE, then three stalled cycles in SHADOW
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h900, 32'h1, 32'h2, 32'h10);
    step();
    exp_br = exp_br + 32'd1;
    exp_tk = exp_tk + 32'd1;
    chk("bne_redirect", {31'd0, bus.o_redirect}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hA00, 32'h1, 32'h1, 32'h4);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d_redirect", k), {31'd0, bus.o_redirect}, 32'd0);
      chk($sformatf("stall%0d_valid", k),    {31'd0, bus.o_valid},    32'd0);
      chk($sformatf("stall%0d_target", k),   bus.o_target,            32'h910);
    end
    bus.i_stall = 1'b0;
    step();
    chk("unstall_drop_valid", {31'd0, bus.o_valid}, 32'd0);
    chk_cnt("unstall_drop");
    step();
    exp_br = exp_br + 32'd1;
    exp_tk = exp_tk + 32'd1;
    chk("unstall_cap_valid",  {31'd0, bus.o_valid}, 32'd1);
    chk("unstall_cap_target", bus.o_target,         32'hA04);
    chk_cnt("unstall_cap");
    idle();
    step();

    // Stall in RUN holds a non-redirect result
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20);
    step();
    exp_br = exp_br + 32'd1;
    chk("runstall_cap_valid", {31'd0, bus.o_valid}, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'hC00, 32'h0, 32'h0, 32'h8);
    step();
    chk("runstall_valid",  {31'd0, bus.o_valid}, 32'd1);
    chk("runstall_target", bus.o_target,         32'h120);
    chk("runstall_link",   bus.o_link,           32'h104);
    chk_cnt("runstall");
    idle();
    step();
    chk("runstall_rel_valid",  {31'd0, bus.o_valid}, 32'd0);
    chk("runstall_rel_target", bus.o_target,         32'h120);

    // Flush together with stall and a taken BEQ
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'hB00, 32'h3, 32'h3, 32'h8);
    step();
    chk("flushstall_valid",    {31'd0, bus.o_valid},    32'd0);
    chk("flushstall_redirect", {31'd0, bus.o_redirect}, 32'd0);
    chk_cnt("flushstall");
    // Flush inside SHADOW returns to RUN immediately
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hB00, 32'h3, 32'h3, 32'h8);
    step();
    exp_br = exp_br + 32'd1;
    exp_tk = exp_tk + 32'd1;
    chk("preflush_redirect", {31'd0, bus.o_redirect}, 32'd1);
    bus.i_flush = 1'b1;
    step();
    chk("shflush_valid", {31'd0, bus.o_valid}, 32'd0);
    chk_cnt("shflush");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hC00, 32'h3, 32'h3, 32'hC);
    step();
    exp_br = exp_br + 32'd1;
    exp_tk = exp_tk + 32'd1;
    chk("postflush_valid",  {31'd0, bus.o_valid}, 32'd1);
    chk("postflush_target", bus.o_target,         32'hC0C);
    chk_cnt("postflush");

    // Reset while in SHADOW, with flush/stall/valid all high
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'hD00, 32'h3, 32'h3, 32'h4);
    reset = 1'b1;
    step();
    exp_br = 32'h0;
    exp_tk = 32'h0;
    chk("midrst_valid",  {31'd0, bus.o_valid}, 32'd0);
    chk("midrst_target", bus.o_target,         32'h0);
    chk("midrst_link",   bus.o_link,           32'h0);
    chk_cnt("midrst");
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hD00, 32'h3, 32'h3, 32'h4);
    step();
    exp_br = exp_br + 32'd1;
    exp_tk = exp_tk + 32'd1;
    chk("postrst_valid",    {31'd0, bus.o_valid},    32'd1);
    chk("postrst_redirect", {31'd0, bus.o_redirect}, 32'd1);
    chk_cnt("postrst");
    idle();
    step();

    // Counter saturation from a preset one below the maximum
    @(negedge clk);
    force dut.br_count_r    = 32'hFFFFFFFE;
    force dut.taken_count_r = 32'hFFFFFFFE;
    #1;
    release dut.br_count_r;
    release dut.taken_count_r;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hE00, 32'h9, 32'h9, 32'h8);
    step();
    exp_br = 32'hFFFFFFFF;
    exp_tk = 32'hFFFFFFFF;
    chk_cnt("sat_reach");
    idle();
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'hE00, 32'h9, 32'h9, 32'h8);
    step();
    chk_cnt("sat_hold");
    idle();
    reset = 1'b1;
    step();
    exp_br = 32'h0;
    exp_tk = 32'h0;
    chk_cnt("sat_rst");
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
